// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encoding, config bit indices and default bus addresses for the UART transmitter.
package uart_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
  localparam int CFG_PAR_EN = 0;
  localparam int CFG_PAR_ODD = 1;
  localparam int CFG_STOP2 = 2;
  localparam logic [3:0] DEF_CFG_ADDR = 4'h6;
  localparam logic [3:0] DEF_STAT_ADDR = 4'h7;
endpackage

// File: rtl/uart_tx_regs.sv
// uart_tx_regs: register-bus decode, one-cycle ack/readback and the line-format config register.
// Parity bits exist only when UART_TX_PARITY_EN is defined; otherwise they are held at 0.
module uart_tx_regs
  import uart_tx_pkg::*;
#(
  parameter logic [3:0] CFG_ADDR = DEF_CFG_ADDR,
  parameter logic [3:0] STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] address,
  input  logic [3:0] data,
  input  logic       valid,
  input  logic       busy,
  input  logic       full,
  output logic       ack,
  output logic [3:0] data_out,
  output logic       data_out_valid,
  output logic [2:0] cfg
);
  logic cfg_hit, stat_hit, ack_q, data_unused;
  logic [2:0] cfg_d;
  logic [3:0] rd_q;
  assign cfg_hit = valid && (address == CFG_ADDR);
  assign stat_hit = valid && (address == STAT_ADDR);
`ifdef UART_TX_PARITY_EN
  assign cfg_d = cfg_hit ? data[2:0] : cfg;
  assign data_unused = data[3];
`else
  assign cfg_d = cfg_hit ? {data[CFG_STOP2], 2'b00} : cfg;
  assign data_unused = ^{data[3], data[1:0]};
`endif
  // Readback carries the post-write config value, or a snapshot of status.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cfg <= 3'd0;
      ack_q <= 1'b0;
      rd_q <= 4'd0;
    end else begin
      cfg <= cfg_d;
      ack_q <= cfg_hit || stat_hit;
      rd_q <= cfg_hit ? {1'b0, cfg_d} : stat_hit ? {2'b00, full, busy} : 4'd0;
    end
  assign ack = ack_q;
  assign data_out_valid = ack_q;
  assign data_out = rd_q;
endmodule

// File: rtl/uart_tx_module.sv
// uart_tx_module: byte-wide UART transmitter, 16x-oversampled, LSB first, 1/2 stop bits.
// Optional parity is built only when UART_TX_PARITY_EN is defined.
module uart_tx_module
  import uart_tx_pkg::*;
#(
  parameter logic [3:0] TX_CFG_ADDR = DEF_CFG_ADDR,
  parameter logic [3:0] TX_STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16bd,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [3:0] address,
  input  logic [3:0] data,
  input  logic       valid,
  output logic       ack,
  output logic [3:0] data_out,
  output logic       data_out_valid,
  output logic       Tx
);
  state_t state, state_d;
  logic [3:0] tick_cnt, tick_d;
  logic [2:0] bit_cnt, bit_d, cfg;
  logic [7:0] shift, shift_d, hold;
  logic full, load, bnd, stop2_q;
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_q;
`else
  logic cfg_unused;
  assign cfg_unused = ^cfg[1:0];
`endif
  uart_tx_regs #(.CFG_ADDR(TX_CFG_ADDR), .STAT_ADDR(TX_STAT_ADDR)) u_regs (
    .clk(clk),
    .rst(rst),
    .address(address),
    .data(data),
    .valid(valid),
    .busy(state != ST_IDLE),
    .full(full),
    .ack(ack),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .cfg(cfg)
  );
  assign tx_ready = !full;
  assign bnd = tick_16bd && (tick_cnt == 4'hF);
  // Format and parity are frozen at load so mid-frame config writes wait for the next frame.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      tick_cnt <= 4'd0;
      bit_cnt <= 3'd0;
      shift <= 8'd0;
      hold <= 8'd0;
      full <= 1'b0;
      stop2_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_d;
      tick_cnt <= tick_d;
      bit_cnt <= bit_d;
      shift <= shift_d;
      full <= !load && (full || tx_valid);
      if (tx_valid && tx_ready) hold <= tx_data;
      if (load) begin
        stop2_q <= cfg[CFG_STOP2];
`ifdef UART_TX_PARITY_EN
        par_en_q <= cfg[CFG_PAR_EN];
        par_q <= ^hold ^ cfg[CFG_PAR_ODD];
`endif
      end
    end
  // In STOP, bit_cnt (0 on entry) marks the second stop bit of a 2-stop frame.
  always_comb begin
    state_d = state;
    tick_d = tick_cnt;
    bit_d = bit_cnt;
    shift_d = shift;
    load = 1'b0;
    Tx = 1'b1;
    if (tick_16bd && state != ST_IDLE) tick_d = tick_cnt + 4'd1;
    case (state)
      ST_IDLE: load = full;
      ST_START: begin
        Tx = 1'b0;
        if (bnd) state_d = ST_DATA;
      end
      ST_DATA: begin
        Tx = shift[0];
        if (bnd) begin
          shift_d = shift >> 1;
          bit_d = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_cnt == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
          if (bit_cnt == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        Tx = par_q;
        if (bnd) state_d = ST_STOP;
      end
`endif
      ST_STOP:
        if (bnd) begin
          if (stop2_q && bit_cnt == 3'd0) bit_d = 3'd1;
          else begin
            state_d = ST_IDLE;
            load = full;
          end
        end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = ST_START;
      shift_d = hold;
      tick_d = 4'd0;
      bit_d = 3'd0;
    end
  end
endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: scoreboard bench; stimulus queues expected frames/readbacks, monitors compare on the line and bus.
module tb_uart_tx_module;
  logic clk = 0, rst = 1, tick_16bd = 0, tx_valid = 0, valid = 0;
  logic [7:0] tx_data = 0;
  logic [3:0] address = 0, data = 0;
  logic tx_ready, ack, data_out_valid, Tx;
  logic [3:0] data_out;
  localparam logic [3:0] CA = 4'h6, SA = 4'h7;

  typedef struct {
    logic [11:0] bits;
    int n;
    bit b2b;
  } frame_t;

  frame_t fq[$];
  logic [3:0] bq[$];
  int errors = 0, checks = 0, frames_done = 0;

`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] RB1 = 4'h1, RB6 = 4'h6, RB7 = 4'h7;
  localparam logic [11:0] F07 = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
  localparam int N07 = 11;
  localparam logic [11:0] F00 = {2'b11, 1'b1, 8'h00, 1'b0};
  localparam logic [11:0] F81 = {2'b11, 1'b1, 8'h81, 1'b0};
  localparam int N2S = 12;
`else
  localparam logic [3:0] RB1 = 4'h0, RB6 = 4'h4, RB7 = 4'h4;
  localparam logic [11:0] F07 = {2'b00, 1'b1, 8'h07, 1'b0};
  localparam int N07 = 10;
  localparam logic [11:0] F00 = {1'b0, 2'b11, 8'h00, 1'b0};
  localparam logic [11:0] F81 = {1'b0, 2'b11, 8'h81, 1'b0};
  localparam int N2S = 11;
`endif

  uart_tx_module dut (
    .clk(clk), .rst(rst), .tick_16bd(tick_16bd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .address(address), .data(data), .valid(valid), .ack(ack),
    .data_out(data_out), .data_out_valid(data_out_valid), .Tx(Tx)
  );

  always #5 clk = ~clk;

  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1 tick_16bd = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line monitor: samples Tx once per tick and checks each bit held for 16 ticks.
  frame_t cur;
  bit active = 0, bad = 0;
  int k = 0, idle = 0, skip = 0;
  always @(negedge clk) begin
    if (!rst) begin
      active = 0;
      idle = 0;
      skip = 0;
    end else if (tick_16bd) begin
      if (skip > 0) skip--;
      else if (!active) begin
        if (Tx === 1'b0) begin
          if (fq.size() == 0) begin
            chk(0, "unexpected_frame", 12'd0, 12'd1);
            skip = 160;
          end else begin
            cur = fq.pop_front();
            active = 1;
            k = 0;
            bad = 0;
            if (cur.b2b) chk(idle == 0, "b2b_gap", 12'(idle), 12'd0);
          end
        end else idle++;
      end
      if (active) begin
        if (Tx !== cur.bits[k/16]) bad = 1;
        if (k % 16 == 15) begin
          chk(!bad, $sformatf("frame_bit%0d", k / 16), 12'(bad), 12'(cur.bits[k/16]));
          bad = 0;
        end
        k++;
        if (k == cur.n * 16) begin
          active = 0;
          idle = 0;
          frames_done++;
        end
      end
    end
  end

  // Bus monitor: every ack pops one expected readback.
  always @(negedge clk) begin
    if (rst && ack === 1'b1) begin
      if (bq.size() == 0) chk(0, "spurious_ack", 12'(data_out), 12'd0);
      else begin
        logic [3:0] e;
        e = bq.pop_front();
        chk(data_out === e && data_out_valid === 1'b1, "readback", 12'(data_out), 12'(e));
      end
    end
  end

  task automatic bus(input logic [3:0] a, input logic [3:0] d, input bit hit, input logic [3:0] exp);
    if (hit) bq.push_back(exp);
    @(negedge clk);
    address = a;
    data = d;
    valid = 1;
    @(negedge clk);
    valid = 0;
    if (!hit) chk(ack === 0 && data_out_valid === 0 && data_out === 0, "no_response", 12'(data_out), 12'd0);
    @(negedge clk);
    chk(ack === 0 && data_out === 0, "ack_one_cycle", 12'({ack, data_out}), 12'd0);
  endtask

  task automatic send(input logic [7:0] b, input logic [11:0] bits, input int n, input bit b2b);
    int w = 0;
    fq.push_back('{bits, n, b2b});
    @(negedge clk);
    tx_data = b;
    tx_valid = 1;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    tx_valid = 0;
    if (w >= 2000) chk(0, "handshake_timeout", 12'(w), 12'd0);
  endtask

  task automatic wait_frames(input int target);
    int w = 0;
    while (frames_done < target && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk(frames_done >= target, "frame_timeout", 12'(frames_done), 12'(target));
  endtask

  initial begin
    #2 rst = 0;
    repeat (3) @(negedge clk);
    chk(Tx === 1'b1, "rst_tx", 12'(Tx), 12'd1);
    chk(tx_ready === 1'b1, "rst_ready", 12'(tx_ready), 12'd1);
    chk(ack === 1'b0 && data_out_valid === 1'b0, "rst_ack", 12'({ack, data_out_valid}), 12'd0);
    chk(data_out === 4'h0, "rst_dout", 12'(data_out), 12'd0);
    rst = 1;
    // 8N1 0xA5 with a mid-frame status read
    send(8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 0);
    repeat (20) @(negedge clk);
    bus(SA, 4'h0, 1, 4'b0001);
    wait_frames(1);
    chk(tx_ready === 1'b1 && Tx === 1'b1, "idle_after_a5", 12'({tx_ready, Tx}), 12'h3);
    // even parity
    bus(CA, 4'b0001, 1, RB1);
    send(8'h07, F07, N07, 0);
    wait_frames(2);
    // odd parity, two stop bits, back-to-back to pin the stop length
    bus(CA, 4'b0110, 1, RB6);
    bus(CA, 4'b0111, 1, RB7);
    send(8'h00, F00, N2S, 0);
    send(8'h81, F81, N2S, 1);
    chk(tx_ready === 1'b0, "holding_full", 12'(tx_ready), 12'd0);
    bus(SA, 4'h0, 1, 4'b0011);
    wait_frames(4);
    // 8N1 back-to-back
    bus(CA, 4'b0000, 1, 4'h0);
    send(8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 0);
    send(8'hAA, {2'b00, 1'b1, 8'hAA, 1'b0}, 10, 1);
    wait_frames(6);
    bus(4'h2, 4'h5, 0, 4'h0);
    // reset mid-DATA with a byte pending
    bus(CA, 4'b0100, 1, 4'b0100);
    send(8'h3C, {1'b0, 2'b11, 8'h3C, 1'b0}, 11, 0);
    send(8'hFF, {1'b0, 2'b11, 8'hFF, 1'b0}, 11, 1);
    repeat (300) @(negedge clk);
    rst = 0;
    #1;
    chk(Tx === 1'b1, "async_rst_tx", 12'(Tx), 12'd1);
    chk(tx_ready === 1'b1, "async_rst_ready", 12'(tx_ready), 12'd1);
    fq.delete();
    bq.delete();
    repeat (3) @(negedge clk);
    rst = 1;
    bus(SA, 4'h0, 1, 4'b0000);
    send(8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 0);
    send(8'h18, {2'b00, 1'b1, 8'h18, 1'b0}, 10, 1);
    wait_frames(8);
    repeat (200) @(negedge clk);
    chk(fq.size() == 0 && bq.size() == 0, "queues_drained", 12'(fq.size() + bq.size()), 12'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_module.md
# uart_tx_module

Serial UART transmitter: the transmit counterpart of the UART receive path. Accepts 8-bit bytes over a valid/ready handshake and shifts them out on `Tx` at the 16x-oversampled baud rate (LSB first, optional parity, 1 or 2 stop bits). Line format is programmed through the shared 4-bit register bus, alongside the clock handler, the UART receive module and the channel processor. Its `ack`/`data_out`/`data_out_valid` outputs join the existing OR-trees.

## Interface
- `TX_CFG_ADDR`, default 4'h6: register-bus address of the config register.
- `TX_STAT_ADDR`, default 4'h7: register-bus address of the read-only status register.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick_16bd` in 1: one-`clk` pulse at 16x baud; single-cycle strobe, not a clock.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the holding register is free.
- `address` in 4: register-bus address.
- `data` in 4: register-bus write data.
- `valid` in 1: register-bus request strobe.
- `ack` out 1: one-cycle acknowledge for own address.
- `data_out` out 4: register readback; 0 when `data_out_valid` is 0.
- `data_out_valid` out 1: qualifies `data_out`.
- `Tx` out 1: serial line, idle high.

## Operation
- Config register:
  - bit0 PAR_EN.
  - bit1 PAR_ODD.
  - bit2 STOP2.
  - bit3 reserved, reads 0.
- Status register, read-only, writes ignored:
  - bit0 busy (FSM not IDLE).
  - bit1 holding register full.
  - bits 3:2 read 0.
- Bus cycle:
  - `valid` with `address` equal to `TX_CFG_ADDR` or `TX_STAT_ADDR` is acknowledged.
  - A config access writes `data[2:0]` into the register.
  - In the next cycle, `ack`=1 and `data_out_valid`=1 for exactly one cycle, with `data_out` carrying the post-write register value.
  - Other addresses produce no response.
- Holding register:
  - A handshake occurs when `tx_valid` && `tx_ready` at a rising edge; the byte is latched and `tx_ready` drops in the next cycle.
  - The holding register empties when the FSM loads the shift register; `tx_ready` rises in that same cycle.
  - This allows back-to-back frames with no idle gap.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `Tx`=1. If the holding register is full, load the shifter, clear the 4-bit tick counter and go to START in the next cycle.
  - START: `Tx`=0 for 16 ticks, then go to DATA.
  - DATA: `Tx`=shift[0] for 16 ticks per bit, 8 bits with a 3-bit bit counter. After bit 7, go to PARITY if PAR_EN, else to STOP.
  - PARITY: `Tx` = XOR of the 8 data bits, XOR PAR_ODD, for 16 ticks.
  - STOP: `Tx`=1 for 16 ticks, or 32 ticks if STOP2. Then go to START directly if the holding register is full (load in the same cycle), else to IDLE.
- Format is sampled at load: config writes made mid-frame take effect from the next frame.

## Timing
- Reset values:
  - `Tx`=1.
  - `tx_ready`=1.
  - `ack`=0, `data_out_valid`=0, `data_out`=0.
  - Config register = 0 (8N1).
  - FSM in IDLE; counters 0.
- Bit period = exactly 16 `tick_16bd` pulses. The tick counter advances only on a tick and wraps 15 -> 0 at each bit boundary.
- Frame length in ticks = 16 x (10 + PAR_EN + STOP2): 160 for 8N1, 176 for 8E1, 192 for 8O2.
- Latency:
  - IDLE handshake to `Tx` falling: 2 `clk` cycles (latch, then load).
  - The first start-bit tick is counted from the cycle after load.
- A handshake and a bus write in the same cycle are independent and both complete.
- Reset asserted mid-frame: `Tx` returns high asynchronously and the pending byte is discarded.
- `tx_valid` held high while `tx_ready`=0: no effect, and the data is not sampled.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: PARITY state, PAR_EN and PAR_ODD are implemented.
  - Undefined: PARITY state is removed, config bits 1:0 are forced to 0 and read 0, and frames are always 8N1/8N2.

## Structure
- Shared package holds:
  - the FSM state encoding (3-bit localparams);
  - config bit indices (CFG_PAR_EN=0, CFG_PAR_ODD=1, CFG_STOP2=2);
  - default register addresses.
- One natural sub-module, `uart_tx_regs`: the bus decode, ack/readback pulse and config register. The serializer FSM stays in `uart_tx_module`.

## Test plan
- Reset, config 0, send 8'hA5 -> `Tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 16 ticks; frame is 160 ticks; `tx_ready` returns to 1.
- Write 4'b0001 to `TX_CFG_ADDR`, send 8'h07 -> `ack`=1 and `data_out`=4'h1 for one cycle. Frame is 176 ticks with parity bit 1 (even parity).
- Config 4'b0110 (odd, 2 stop, parity disabled) then 4'b0111, send 8'h00 -> parity bit 1, stop high for 32 ticks, frame 192 ticks.
- Two bytes 8'h55 and 8'hAA offered back-to-back -> second handshake accepted during the first frame. The second start bit follows the first stop bit with zero idle ticks.
- Read `TX_STAT_ADDR` mid-frame -> `data_out`=4'b0001 or 4'b0011. A bus access to 4'h2 -> no `ack`, `data_out`=0.
- Assert `rst` mid-DATA -> `Tx`=1 immediately, `tx_ready`=1, config reads 0. The next byte after release is sent as a clean 8N1 frame.
